// File: rtl/grb_pkg.sv
// Shared GRB LED-protocol definitions: receiver states, pixel width and default timing at 50 MHz.
package grb_pkg;

   typedef enum logic [1:0] {
      WAIT_GAP,
      READY,
      HIGH,
      LOW
   } rx_state_t;

   localparam int PIXEL_BITS        = 24;
   localparam int DEF_T1_THRESH_CYC = 30;
   localparam int DEF_MIN_HIGH_CYC  = 5;
   localparam int DEF_MAX_HIGH_CYC  = 60;
   localparam int DEF_RESET_CYC     = 2500;
   localparam int DEF_CNT_W         = 13;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clearing while incrementing loads 1 so a new interval can start counted.
module sat_counter #(
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= {{(W-1){1'b0}}, inc};
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/grb_pixel_receiver.sv
// Single-wire GRB receiver: pulse-width bit decode, 24-bit pixel assembly, latch-gap frame end.
// Define GRB_RX_REORDER_EN to present pixel_data as {R,G,B} instead of wire order {G,R,B}.
module grb_pixel_receiver
   import grb_pkg::*;
#(
   parameter int T1_THRESH_CYC = DEF_T1_THRESH_CYC,
   parameter int MIN_HIGH_CYC  = DEF_MIN_HIGH_CYC,
   parameter int MAX_HIGH_CYC  = DEF_MAX_HIGH_CYC,
   parameter int RESET_CYC     = DEF_RESET_CYC,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  din,
   output logic [PIXEL_BITS-1:0] pixel_data,
   output logic                  pixel_valid,
   output logic [CNT_W-1:0]      pixel_index,
   output logic                  frame_done,
   output logic                  bit_error,
   output logic                  busy
);

   localparam logic [CNT_W-1:0] T1_C     = CNT_W'(T1_THRESH_CYC);
   localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HIGH_CYC);
   localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RESET_CYC - 1);
   localparam logic [4:0]       LAST_BIT = 5'(PIXEL_BITS - 1);

   rx_state_t             state;
   logic                  din_m, din_s, din_d;
   logic [4:0]            bit_cnt;
   logic [PIXEL_BITS-1:0] shift, shift_next, pixel_word;
   logic [CNT_W-1:0]      high_cnt, low_cnt, pix_cnt;
   logic                  high_clr, high_inc, low_clr, low_inc, pix_clr, pix_inc;
   logic                  rise, fall, glitch, bit_one, timeout, gap_done;

   // NOTE: din is asynchronous; two flops settle metastability, the third gives the edge reference.
   always_ff @(posedge clk) begin
      if (reset) begin
         din_m <= 1'b0;
         din_s <= 1'b0;
         din_d <= 1'b0;
      end else begin
         din_m <= din;
         din_s <= din_m;
         din_d <= din_s;
      end
   end

   assign rise       = din_s & ~din_d;
   assign fall       = ~din_s & din_d;
   assign glitch     = high_cnt < MIN_C;
   assign bit_one    = high_cnt >= T1_C;
   assign timeout    = din_s && (high_cnt >= MAX_LAST);
   assign gap_done   = !din_s && (low_cnt >= GAP_LAST);
   assign shift_next = {shift[PIXEL_BITS-2:0], bit_one};
   assign busy       = (state == HIGH) || (state == LOW);

`ifdef GRB_RX_REORDER_EN
   assign pixel_word = {shift_next[15:8], shift_next[23:16], shift_next[7:0]};
`else
   assign pixel_word = shift_next;
`endif

   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      high_clr = 1'b0;
      high_inc = 1'b0;
      low_clr  = 1'b0;
      low_inc  = 1'b0;
      pix_clr  = 1'b0;
      pix_inc  = 1'b0;
      unique case (state)
         WAIT_GAP: begin
            low_clr = din_s;
            low_inc = !din_s;
         end
         READY: begin
            high_clr = rise;
            high_inc = rise;
         end
         HIGH: begin
            if (fall) begin
               low_clr = 1'b1;
               low_inc = !glitch;
               pix_clr = glitch;
               pix_inc = !glitch && (bit_cnt == LAST_BIT);
            end else if (timeout) begin
               low_clr = 1'b1;
               pix_clr = 1'b1;
            end else begin
               high_inc = 1'b1;
            end
         end
         LOW: begin
            if (rise) begin
               high_clr = 1'b1;
               high_inc = 1'b1;
            end else if (gap_done) begin
               pix_clr = 1'b1;
            end else begin
               low_inc = 1'b1;
            end
         end
         default: ;
      endcase
   end

   sat_counter #(.W(CNT_W)) u_high_cnt (
      .clk(clk), .reset(reset), .clr(high_clr), .inc(high_inc), .cnt(high_cnt)
   );
   sat_counter #(.W(CNT_W)) u_low_cnt (
      .clk(clk), .reset(reset), .clr(low_clr), .inc(low_inc), .cnt(low_cnt)
   );
   sat_counter #(.W(CNT_W)) u_pix_cnt (
      .clk(clk), .reset(reset), .clr(pix_clr), .inc(pix_inc), .cnt(pix_cnt)
   );

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= WAIT_GAP;
         bit_cnt     <= '0;
         shift       <= '0;
         pixel_data  <= '0;
         pixel_valid <= 1'b0;
         pixel_index <= '0;
         frame_done  <= 1'b0;
         bit_error   <= 1'b0;
      end else begin
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         bit_error   <= 1'b0;
         unique case (state)
            WAIT_GAP: if (gap_done) state <= READY;
            READY:    if (rise) state <= HIGH;
            HIGH: begin
               if (fall && glitch) begin
                  bit_error <= 1'b1;
                  bit_cnt   <= '0;
                  state     <= WAIT_GAP;
               end else if (fall) begin
                  shift <= shift_next;
                  state <= LOW;
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt     <= '0;
                     pixel_valid <= 1'b1;
                     pixel_data  <= pixel_word;
                     pixel_index <= pix_cnt;
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end else if (timeout) begin
                  bit_error <= 1'b1;
                  bit_cnt   <= '0;
                  state     <= WAIT_GAP;
               end
            end
            LOW: begin
               if (rise) begin
                  state <= HIGH;
               end else if (gap_done) begin
                  // LOW is only reachable after a decoded bit, so the frame is never empty here.
                  frame_done <= 1'b1;
                  bit_error  <= (bit_cnt != '0);
                  bit_cnt    <= '0;
                  state      <= READY;
               end
            end
            default: state <= WAIT_GAP;
         endcase
      end
   end

endmodule

// File: tb/tb_grb_pixel_receiver.sv
// Directed bench for grb_pixel_receiver; honours GRB_RX_REORDER_EN for expected pixel order.
module tb_grb_pixel_receiver;

   logic        clk = 1'b0;
   logic        reset;
   logic        din;
   logic [23:0] pixel_data;
   logic        pixel_valid;
   logic [12:0] pixel_index;
   logic        frame_done;
   logic        bit_error;
   logic        busy;

   int total = 0;
   int bad   = 0;

   // Event log written only by the monitor; the test reads deltas against snapshots.
   logic [23:0] pv_data[$];
   logic [12:0] pv_idx[$];
   int fd_n = 0, be_n = 0, both_n = 0, pv_fd_n = 0;
   int pv_base, fd_base, be_base, both_base;

   grb_pixel_receiver dut (
      .clk(clk), .reset(reset), .din(din),
      .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_index(pixel_index),
      .frame_done(frame_done), .bit_error(bit_error), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (pixel_valid) begin
            pv_data.push_back(pixel_data);
            pv_idx.push_back(pixel_index);
         end
         if (frame_done) fd_n++;
         if (bit_error) be_n++;
         if (bit_error && frame_done) both_n++;
         if (pixel_valid && frame_done) pv_fd_n++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] present(input logic [23:0] w);
`ifdef GRB_RX_REORDER_EN
      return {w[15:8], w[23:16], w[7:0]};
`else
      return w;
`endif
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int hi, input int lo);
      din = 1'b1;
      repeat (hi) @(negedge clk);
      din = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic send_pixel(input logic [23:0] px);
      for (int i = 23; i >= 0; i--) begin
         if (px[i]) pulse(40, 22);
         else       pulse(20, 42);
      end
   endtask

   task automatic snap();
      pv_base   = pv_data.size();
      fd_base   = fd_n;
      be_base   = be_n;
      both_base = both_n;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_data"},  32'(pixel_data),  32'h0);
      check({tag, "_valid"}, 32'(pixel_valid), 32'h0);
      check({tag, "_index"}, 32'(pixel_index), 32'h0);
      check({tag, "_frame"}, 32'(frame_done),  32'h0);
      check({tag, "_err"},   32'(bit_error),   32'h0);
      check({tag, "_busy"},  32'(busy),        32'h0);
   endtask

   initial begin
      reset = 1'b1;
      din   = 1'b0;
      idle(5);
      check_outputs_zero("reset");
      reset = 1'b0;

      // 1: power-up gap, single pixel, latch
      snap();
      idle(2600);
      send_pixel(24'hFF0000);
      idle(5);
      check("t1_pv_count", 32'(pv_data.size() - pv_base), 32'd1);
      check("t1_data", 32'(pv_data[pv_base]), 32'(present(24'hFF0000)));
      check("t1_index", 32'(pv_idx[pv_base]), 32'd0);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_no_fd_yet", 32'(fd_n - fd_base), 32'd0);
      idle(2600);
      check("t1_fd", 32'(fd_n - fd_base), 32'd1);
      check("t1_no_err", 32'(be_n - be_base), 32'd0);
      check("t1_idle_busy", 32'(busy), 32'd0);
      check("t1_hold", 32'(pixel_data), 32'(present(24'hFF0000)));

      // 2: three pixels, then index restarts in the next frame
      snap();
      send_pixel(24'h123456);
      send_pixel(24'hABCDEF);
      send_pixel(24'h000001);
      idle(2600);
      check("t2_pv_count", 32'(pv_data.size() - pv_base), 32'd3);
      check("t2_d0", 32'(pv_data[pv_base]),     32'(present(24'h123456)));
      check("t2_d1", 32'(pv_data[pv_base + 1]), 32'(present(24'hABCDEF)));
      check("t2_d2", 32'(pv_data[pv_base + 2]), 32'(present(24'h000001)));
      check("t2_i0", 32'(pv_idx[pv_base]),     32'd0);
      check("t2_i1", 32'(pv_idx[pv_base + 1]), 32'd1);
      check("t2_i2", 32'(pv_idx[pv_base + 2]), 32'd2);
      check("t2_fd", 32'(fd_n - fd_base), 32'd1);
      snap();
      send_pixel(24'h3C3C3C);
      idle(2600);
      check("t2_restart_data", 32'(pv_data[pv_base]), 32'(present(24'h3C3C3C)));
      check("t2_restart_index", 32'(pv_idx[pv_base]), 32'd0);

      // 3: width boundaries 29->0, 30->1, 5->0 (not a glitch), 59->1 (no timeout)
      snap();
      pulse(29, 42);
      pulse(30, 42);
      pulse(5, 42);
      pulse(59, 42);
      for (int i = 0; i < 20; i++) pulse(20, 42);
      idle(2600);
      check("t3_pv_count", 32'(pv_data.size() - pv_base), 32'd1);
      check("t3_data", 32'(pv_data[pv_base]), 32'(present(24'h500000)));
      check("t3_no_err", 32'(be_n - be_base), 32'd0);
      snap();
      pulse(4, 20);
      check("t3_glitch_err", 32'(be_n - be_base), 32'd1);
      check("t3_glitch_busy", 32'(busy), 32'd0);
      idle(80);
      send_pixel(24'hFFFFFF);
      idle(5);
      check("t3_wait_gap_no_pv", 32'(pv_data.size() - pv_base), 32'd0);
      idle(2600);

      // 4: 60-cycle high times out; recovery needs a fresh gap
      snap();
      pulse(60, 20);
      check("t4_timeout_err", 32'(be_n - be_base), 32'd1);
      idle(80);
      send_pixel(24'h0F0F0F);
      idle(5);
      check("t4_no_pv", 32'(pv_data.size() - pv_base), 32'd0);
      idle(2600);
      send_pixel(24'hA5A5A5);
      idle(2600);
      check("t4_recover_count", 32'(pv_data.size() - pv_base), 32'd1);
      check("t4_recover_data", 32'(pv_data[pv_base]), 32'(present(24'hA5A5A5)));
      check("t4_recover_index", 32'(pv_idx[pv_base]), 32'd0);

      // 5: partial pixel at latch gives error and frame_done together
      snap();
      for (int i = 0; i < 10; i++) pulse(40, 22);
      idle(2600);
      check("t5_err", 32'(be_n - be_base), 32'd1);
      check("t5_fd", 32'(fd_n - fd_base), 32'd1);
      check("t5_coincident", 32'(both_n - both_base), 32'd1);
      check("t5_no_pv", 32'(pv_data.size() - pv_base), 32'd0);

      // 6: reset mid-pixel, then a clean pixel after a gap
      snap();
      for (int i = 0; i < 12; i++) pulse(40, 22);
      reset = 1'b1;
      idle(3);
      check_outputs_zero("t6_reset");
      reset = 1'b0;
      idle(2600);
      send_pixel(24'h00FF00);
      idle(2600);
      check("t6_pv_count", 32'(pv_data.size() - pv_base), 32'd1);
      check("t6_data", 32'(pv_data[pv_base]), 32'(present(24'h00FF00)));
      check("t6_index", 32'(pv_idx[pv_base]), 32'd0);
      check("t6_fd", 32'(fd_n - fd_base), 32'd1);

      check("never_pv_with_fd", 32'(pv_fd_n), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/grb_pixel_receiver.md
Name: grb_pixel_receiver

Overview:
Single-wire GRB LED-protocol receiver, the inverse of the team's GRB transmit path (GRBStateMachine plus its bit counter). It samples the serial data line and classifies each high pulse as a 0 or 1 bit by its width. It assembles 24-bit pixels MSB-first and flags the end-of-frame latch gap. It is used for loopback self-test of the transmitter and for reading an upstream LED-chain controller.

Parameters:
T1_THRESH_CYC, 30, high-pulse width (clk cycles) at or above which a bit decodes as 1; 50 MHz gives 0.6 us.
MIN_HIGH_CYC, 5, high pulses shorter than this are glitches and raise an error.
MAX_HIGH_CYC, 60, high-pulse timeout in cycles; reaching it is an error.
RESET_CYC, 2500, low time that marks latch/frame end; 50 us at 50 MHz.
CNT_W, 13, width of the pulse counters and of pixel_index.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
din  in  1  asynchronous serial data line
pixel_data  out  24  last completed pixel, wire order {G,R,B}
pixel_valid  out  1  one-cycle strobe; pixel_data is updated in that cycle
pixel_index  out  CNT_W  index of the pixel currently being strobed, 0-based within the frame
frame_done  out  1  one-cycle strobe when the latch gap ends a frame containing at least 1 bit
bit_error  out  1  one-cycle strobe on glitch, timeout or partial pixel
busy  out  1  high in states HIGH and LOW

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk.
- din passes through a 2-flop synchronizer to give din_s. Edges are detected against a third registered copy. Pin-to-decision latency is 3 clk.
- Reset values: all outputs 0, state = WAIT_GAP, all counters 0, shift register 0.
- WAIT_GAP: count consecutive low cycles of din_s; any high clears the count.
  - Count reaches RESET_CYC -> READY. No frame_done is issued here.
- READY: rising edge -> HIGH, with high_cnt = 1.
- HIGH: high_cnt increments each cycle.
  - Falling edge with high_cnt < MIN_HIGH_CYC -> bit_error, go to WAIT_GAP.
  - Falling edge otherwise -> shift in the bit (high_cnt >= T1_THRESH_CYC gives 1), increment bit_cnt, go to LOW with low_cnt = 1.
  - high_cnt reaching MAX_HIGH_CYC while still high -> bit_error, go to WAIT_GAP.
- On the 24th bit: pixel_valid = 1 in the next cycle, pixel_data = shift register, pixel_index = pix_cnt. Then bit_cnt = 0 and pix_cnt increments.
- pix_cnt saturates at 2^CNT_W-1. Further pixels are still strobed with that same index.
- LOW: low_cnt increments each cycle.
  - Rising edge -> HIGH. The low width between bits is not checked.
  - low_cnt reaching RESET_CYC ends the frame:
    - If bit_cnt != 0, the partial pixel is discarded and bit_error pulses.
    - If any bit was received in the frame, frame_done pulses in the same cycle.
    - pix_cnt and bit_cnt clear, go to READY.
- Simultaneous events: pixel_valid and frame_done are never coincident, because the latch is at least RESET_CYC after the last bit. bit_error and frame_done may coincide (partial pixel).
- Counters are CNT_W wide and saturate; they never wrap.
- Reset mid-frame: everything returns to reset values immediately. A new frame is accepted only after a full gap in WAIT_GAP.
- pixel_data holds its value between strobes.

Optional Feature:
- Macro GRB_RX_REORDER_EN.
- Defined: pixel_data is presented as {R,G,B}, i.e. bytes [15:8] and [23:16] of the wire order are swapped.
- Undefined: wire order {G,R,B} is kept.
- Strobe timing is identical in both cases.

Decomposition:
- Package grb_pkg: state enum (WAIT_GAP, READY, HIGH, LOW), PIXEL_BITS = 24, and the default timing constants, shared with the transmitter.
- Sub-module sat_counter (clear/inc/saturate, CNT_W wide), instantiated for high_cnt, low_cnt and pix_cnt.

Test Plan:
1. Power-up: hold din low for 2500 cycles, then send 24 bits of 0xFF0000 (high 40/low 22 for 1s, high 20/low 42 for 0s) -> one pixel_valid with pixel_data = 0xFF0000 and pixel_index = 0. Then 2500 cycles low -> frame_done.
2. Three pixels 0x123456, 0xABCDEF, 0x000001 then the gap -> three strobes with indices 0, 1, 2, then one frame_done; the next frame restarts at index 0.
3. Threshold edges: high of 29 cycles decodes as 0, high of 30 decodes as 1; high of 4 gives bit_error and the state goes to WAIT_GAP.
4. Timeout: hold din high for 60 cycles -> bit_error at the 60th cycle; no pixel_valid until a fresh 2500-cycle gap plus a full pixel.
5. 10 bits then the gap -> bit_error and frame_done in the same cycle; no pixel_valid.
6. Assert reset after bit 12 of a pixel -> all outputs 0. The following pixel 0x00FF00, sent after a gap, decodes correctly; with GRB_RX_REORDER_EN it reads 0xFF0000.
